// File: rtl/mem_wait_ctrl.sv
// Memory-stage stall controller: issues req/ack accesses, freezes the pipeline via en, captures read data.
// Optional MEM_WAIT_CTRL_EXT_STALL_EN adds stall_in, which gates en and stretches DONE.
module mem_wait_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_req,
    input  logic              acc_we,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
`ifdef MEM_WAIT_CTRL_EXT_STALL_EN
    input  logic              stall_in,
`endif
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              en,
    output logic              timeout_err
);

    // A TIMEOUT of 1 still needs a 1-bit counter to keep the compare well formed.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             stall;
    logic             hit_limit;

`ifdef MEM_WAIT_CTRL_EXT_STALL_EN
    assign stall = stall_in;
`else
    assign stall = 1'b0;
`endif

    assign hit_limit = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (acc_req) state_nxt = BUSY;
            BUSY: if (mem_ack || hit_limit) state_nxt = DONE;
            DONE: if (!stall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        en = 1'b0;
        en = (((state == IDLE) && !acc_req) || (state == DONE)) && !stall;
    end

    // Memory-side request registers, wait counter and captured data; ack beats the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (acc_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= acc_we;
                        mem_addr  <= acc_addr;
                        mem_wdata <= acc_wdata;
                        cnt       <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) rdata <= mem_rdata;
                    end else if (hit_limit) begin
                        mem_req     <= 1'b0;
                        rdata       <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
